// File: rtl/det_count_display.sv
// Detection tally display: counts rising edges of the detector flag, shows the BCD digit
// on a 7-segment driver and lights dp for HOLD_CYCLES after each count. Macro: DET_SATURATE_EN.
module det_count_display #(
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       det_in,
    input  logic       ena,
    input  logic       clr,
    output logic [7:0] seg,
    output logic [3:0] count,
    output logic       ovf
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

    logic       det_q;
    logic [3:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic [7:0] hold_q, hold_d;
    logic [0:0] state_q, state_d;
    logic [7:0] seg_q, seg_d;
    logic [6:0] digit_seg;
    logic       det_edge;
    logic       upd;

    assign det_edge = det_in & ~det_q;
    assign upd      = det_edge & ena & ~clr;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = 4'd0;
            ovf_d   = 1'b0;
        end else if (upd) begin
            if (count_q == 4'd9) begin
                ovf_d = 1'b1;
`ifdef DET_SATURATE_EN
                count_d = 4'd9;
`else
                count_d = 4'd0;
`endif
            end else begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // A retrigger reloads the window rather than extending it.
    always_comb begin
        hold_d = hold_q;
        if (clr) begin
            hold_d = 8'd0;
        end else if (upd) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != 8'd0) begin
            hold_d = hold_q - 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (upd) state_d = SHOW;
                SHOW:    if (hold_d == 8'd0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        case (count_q)
            4'd0:    digit_seg = 7'h3F;
            4'd1:    digit_seg = 7'h06;
            4'd2:    digit_seg = 7'h5B;
            4'd3:    digit_seg = 7'h4F;
            4'd4:    digit_seg = 7'h66;
            4'd5:    digit_seg = 7'h6D;
            4'd6:    digit_seg = 7'h7D;
            4'd7:    digit_seg = 7'h07;
            4'd8:    digit_seg = 7'h7F;
            4'd9:    digit_seg = 7'h6F;
            default: digit_seg = 7'h79;
        endcase
        seg_d = {(state_q == SHOW), digit_seg};
    end

    // Segments are one register behind the tally so the display always lags the count by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_q   <= 1'b0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            hold_q  <= 8'd0;
            state_q <= IDLE;
            seg_q   <= 8'h3F;
        end else begin
            det_q   <= det_in;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            seg_q   <= seg_d;
        end
    end

    assign seg   = seg_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_det_count_display.sv
// Testbench for det_count_display: directed test-plan steps plus random stimulus against
// a behavioural tally/window model.
module tb_det_count_display;

    localparam int HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic       det_in;
    logic       ena;
    logic       clr;
    logic [7:0] seg;
    logic [3:0] count;
    logic       ovf;

    int         nAsserts = 0;
    int         nFail    = 0;

    int         mCount;
    bit         mOvf;
    int         mHold;
    bit         mPrevDet;
    logic [7:0] expSeg;
    int         lit;

    det_count_display #(.HOLD_CYCLES(HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .det_in (det_in),
        .ena    (ena),
        .clr    (clr),
        .seg    (seg),
        .count  (count),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] digitPattern(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Reference: one clock of the tally, evaluated with the inputs sampled at that edge.
    task automatic modelClock(input bit d, input bit e, input bit c);
        bit rise;
        expSeg   = {(mHold > 0), digitPattern(mCount)};
        rise     = d && !mPrevDet;
        mPrevDet = d;
        if (c) begin
            mCount = 0;
            mOvf   = 0;
            mHold  = 0;
        end else if (rise && e) begin
            mHold = HOLD;
            if (mCount == 9) begin
                mOvf = 1;
`ifdef DET_SATURATE_EN
                mCount = 9;
`else
                mCount = 0;
`endif
            end else begin
                mCount = mCount + 1;
            end
        end else if (mHold > 0) begin
            mHold = mHold - 1;
        end
    endtask

    task automatic checkOutput(input string tag);
        nAsserts++;
        assert (count === 4'(mCount)) else begin
            nFail++;
            $error("[TB] FAIL %s count: observed %0d expected %0d", tag, count, mCount);
        end
        nAsserts++;
        assert (ovf === mOvf) else begin
            nFail++;
            $error("[TB] FAIL %s ovf: observed %0b expected %0b", tag, ovf, mOvf);
        end
        nAsserts++;
        assert (seg === expSeg) else begin
            nFail++;
            $error("[TB] FAIL %s seg: observed %h expected %h", tag, seg, expSeg);
        end
    endtask

    task automatic checkConst(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic applyStimulus(input bit d, input bit e, input bit c, input string tag);
        det_in = d;
        ena    = e;
        clr    = c;
        @(posedge clk);
        modelClock(d, e, c);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    task automatic applyReset(input bit detLevel, input string tag);
        rst_n  = 1'b0;
        ena    = 1'b0;
        clr    = 1'b0;
        #1;
        mCount   = 0;
        mOvf     = 0;
        mHold    = 0;
        mPrevDet = 0;
        expSeg   = 8'h3F;
        checkOutput(tag);
        @(negedge clk);
        det_in = detLevel;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        det_in = 1'b0;
        ena    = 1'b0;
        clr    = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        applyReset(1'b0, "reset_init");

        // Single detection held high for three cycles
        lit = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, "single_high");
            lit += int'(seg[7]);
        end
        checkConst("single_count", {4'd0, count}, 8'd1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, 0, "single_low");
            lit += int'(seg[7]);
        end
        checkConst("single_lit_cycles", 8'(lit), 8'(HOLD));
        checkConst("single_final_seg", seg, 8'h06);

        // Ten detections at minimum spacing
        applyStimulus(0, 1, 1, "ten_clear");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0, "ten_rise");
            applyStimulus(0, 1, 0, "ten_fall");
        end
        checkConst("ten_ovf", {7'd0, ovf}, 8'd1);
`ifdef DET_SATURATE_EN
        checkConst("ten_count", {4'd0, count}, 8'd9);
        checkConst("ten_seg", seg, 8'hEF);
`else
        checkConst("ten_count", {4'd0, count}, 8'd0);
        checkConst("ten_seg", seg, 8'hBF);
`endif

        // clr collides with a rising edge at count 3
        applyStimulus(0, 1, 1, "coll_clear");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, "coll_rise");
            applyStimulus(0, 1, 0, "coll_fall");
        end
        checkConst("coll_pre_count", {4'd0, count}, 8'd3);
        applyStimulus(1, 1, 1, "coll_edge_clr");
        applyStimulus(1, 1, 0, "coll_held");
        checkConst("coll_seg", seg, 8'h3F);
        applyStimulus(0, 1, 0, "coll_fall2");
        checkConst("coll_count", {4'd0, count}, 8'd0);
        checkConst("coll_ovf", {7'd0, ovf}, 8'd0);

        // ena gating and input already high when ena rises
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, "gate_rise");
            applyStimulus(0, 0, 0, "gate_fall");
        end
        applyStimulus(1, 0, 0, "gate_high_off");
        applyStimulus(1, 1, 0, "gate_high_on");
        applyStimulus(1, 1, 0, "gate_high_on2");
        checkConst("gate_count", {4'd0, count}, 8'd0);
        applyStimulus(0, 1, 0, "gate_fall_on");
        applyStimulus(1, 1, 0, "gate_rise_on");
        checkConst("gate_count_after", {4'd0, count}, 8'd1);

        // Retrigger four cycles into the window
        applyStimulus(0, 1, 1, "retrig_clear");
        applyStimulus(0, 1, 0, "retrig_idle");
        lit = 0;
        applyStimulus(1, 1, 0, "retrig_edge1");
        lit += int'(seg[7]);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, "retrig_gap");
            lit += int'(seg[7]);
        end
        applyStimulus(1, 1, 0, "retrig_edge2");
        lit += int'(seg[7]);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 1, 0, "retrig_tail");
            lit += int'(seg[7]);
        end
        checkConst("retrig_lit_cycles", 8'(lit), 8'd12);
        checkConst("retrig_count", {4'd0, count}, 8'd2);

        // Reset in the middle of a window at count 5
        applyStimulus(0, 1, 1, "rst_clear");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, "rst_rise");
            applyStimulus(0, 1, 0, "rst_fall");
        end
        checkConst("rst_pre_count", {4'd0, count}, 8'd5);
        applyReset(1'b0, "rst_mid_window");
        applyStimulus(0, 1, 0, "rst_after");
        checkConst("rst_after_seg", seg, 8'h3F);

        // det_in high at reset release counts on the first clock
        applyReset(1'b1, "rst_det_high");
        applyStimulus(1, 1, 0, "rst_release_edge");
        checkConst("rst_release_count", {4'd0, count}, 8'd1);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 19) == 0),
                          "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
